// File: rtl/instr_fetch.sv
// instr_fetch: PC/request generator with in-flight PC tracking and a small instruction buffer
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [6:0]  opcode,
  output logic [31:0] pc_out,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] fpc;
  logic [CW-1:0] outstanding, out_n, fcnt, fcnt_n;
  logic [CW:0] total;
  logic [AW-1:0] wp, rp, iwp, irp;
  logic [31:0] fifo_pc [DEPTH];
  logic [31:0] fifo_word [DEPTH];
  logic [31:0] inflight [DEPTH];
  logic grant, resp, push, pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // Credit covers both in-flight and buffered words, so a push never finds the buffer full
  assign total       = {1'b0, outstanding} + {1'b0, fcnt};
  assign imem_req    = state == RUN && !redirect && total < (CW+1)'(DEPTH);
  assign imem_addr   = fpc;
  assign grant       = imem_req & imem_gnt;
  assign resp        = imem_rvalid && outstanding != '0;
  assign push        = resp && state == RUN && !redirect;
  assign instr_valid = fcnt != '0;
  assign pop         = instr_valid & instr_ready;
  assign instruction = instr_valid ? fifo_word[rp] : '0;
  assign pc_out      = instr_valid ? fifo_pc[rp] : '0;
  assign opcode      = instruction[6:0];
  assign out_n       = outstanding + CW'(grant) - CW'(resp);
  assign fcnt_n      = redirect ? '0 : fcnt + CW'(push) - CW'(pop);
  // Responses still owed after a redirect belong to the old path and are drained
  always_comb begin
    state_n = state == IDLE ? RUN :
              state == RUN  ? (redirect && out_n != '0 ? DRAIN : RUN) :
                              (redirect || out_n != '0 ? DRAIN : RUN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fpc         <= RESET_PC;
      outstanding <= '0;
      fcnt        <= '0;
      wp          <= '0;
      rp          <= '0;
      iwp         <= '0;
      irp         <= '0;
    end else begin
      state       <= state_n;
      outstanding <= out_n;
      fcnt        <= fcnt_n;
      fpc         <= redirect ? redirect_target & ~32'h3 : grant ? fpc + 32'd4 : fpc;
      iwp         <= grant ? inc(iwp) : iwp;
      irp         <= resp ? inc(irp) : irp;
      wp          <= push ? inc(wp) : wp;
      rp          <= redirect ? wp : pop ? inc(rp) : rp;
    end
  end
  always_ff @(posedge clk) begin
    if (grant) inflight[iwp] <= fpc;
    if (push) begin
      fifo_pc[wp]   <= inflight[irp];
      fifo_word[wp] <= imem_rdata;
    end
  end
endmodule
